// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED event scheduler: source indices, FSM states, pattern layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package led_sched_pkg;

  localparam int NUM_SRC = 4;

  localparam logic [1:0] SRC_CM   = 2'd0;
  localparam logic [1:0] SRC_UERR = 2'd1;
  localparam logic [1:0] SRC_CFG  = 2'd2;
  localparam logic [1:0] SRC_DATA = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int PAT_SRC_LSB = 12;
  localparam int PAT_OVF_BIT = 11;

  localparam logic [3:0] CODE_CM   = 4'b1000;
  localparam logic [3:0] CODE_UERR = 4'b0100;
  localparam logic [3:0] CODE_CFG  = 4'b0010;
  localparam logic [3:0] CODE_DATA = 4'b0001;

  function automatic logic [3:0] src_code(input logic [1:0] idx);
    case (idx)
      SRC_CM:   src_code = CODE_CM;
      SRC_UERR: src_code = CODE_UERR;
      SRC_CFG:  src_code = CODE_CFG;
      default:  src_code = CODE_DATA;
    endcase
  endfunction

  function automatic logic [15:0] make_pattern(input logic [1:0] idx, input logic ovf,
                                               input logic [7:0] payload);
    make_pattern = {src_code(idx), ovf, 3'b000, payload};
  endfunction

endpackage

// File: rtl/led_event_scheduler_if.sv
// Event inputs from the protocol blocks and the LED-side outputs of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are fire-and-forget, collisions are counted as drops.
interface led_event_scheduler_if;
  logic       UART_data_debug_switch;
  logic [7:0] UART_data;
  logic       UART_data_valid;
  logic [3:0] CM_errors;
  logic       CM_errors_valid;
  logic [1:0] UART_errors;
  logic       UART_errors_valid;
  logic [7:0] config_notification;
  logic [15:0] leds;
  logic        busy;
  logic [7:0]  drop_count;

  modport master (
    output UART_data_debug_switch, UART_data, UART_data_valid,
           CM_errors, CM_errors_valid, UART_errors, UART_errors_valid,
           config_notification,
    input  leds, busy, drop_count
  );

  modport slave (
    input  UART_data_debug_switch, UART_data, UART_data_valid,
           CM_errors, CM_errors_valid, UART_errors, UART_errors_valid,
           config_notification,
    output leds, busy, drop_count
  );
endinterface

// File: rtl/led_rr_arbiter.sv
// Four-way round-robin arbiter: combinational grant from a registered pointer.
// Latency: grant is same-cycle; pointer moves on the edge where advance is high.
// Backpressure: pointer holds while advance is low, so an unused grant is re-offered.
module led_rr_arbiter
  import led_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       advance,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld
);

  logic [1:0] ptr;
  logic [1:0] idx;

  // Scan from lowest priority up so the last hit is the one nearest the pointer.
  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    gnt_vld = 1'b0;
    idx     = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + k[1:0];
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= SRC_CM;
    end else if (advance && gnt_vld) begin
      ptr <= gnt_idx + 2'd1;
    end
  end

endmodule

// File: rtl/led_event_scheduler.sv
// Time-shares the LED bank among CM error, UART error, config and UART data events.
// Latency: strobe at edge k is pending, shown after edge k+1 when idle; HOLD_CYCLES on, 1 blank.
// Backpressure: none; a second event on a pending slot overwrites it, sets ovf and bumps drop_count.
module led_event_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 25_000_000,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input logic                 clk,
  input logic                 rst,
  led_event_scheduler_if.slave bus
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      leds_q;
  logic             busy_q;
  logic [7:0]       drop_q;

  logic [3:0] pend;
  logic [3:0] ovf;
  logic [7:0] payload [NUM_SRC];
  logic [7:0] cfg_prev;

  logic [3:0] cap;
  logic [7:0] cap_dat [NUM_SRC];
  logic [3:0] clr;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [3:0] gnt_eff;
  logic [3:0] drop;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       take;
  logic [2:0] drop_sum;
  logic [8:0] drop_total;

  always_comb begin
    cap               = '0;
    cap[SRC_CM]       = bus.CM_errors_valid;
    cap[SRC_UERR]     = bus.UART_errors_valid;
    cap[SRC_CFG]      = (bus.config_notification != cfg_prev);
    cap[SRC_DATA]     = bus.UART_data_valid & bus.UART_data_debug_switch;
    cap_dat[SRC_CM]   = {4'b0000, bus.CM_errors};
    cap_dat[SRC_UERR] = {6'b000000, bus.UART_errors};
    cap_dat[SRC_CFG]  = bus.config_notification;
    cap_dat[SRC_DATA] = bus.UART_data;
  end

  // With debug off the DATA slot is flushed and never offered to the arbiter.
  assign clr     = {~bus.UART_data_debug_switch, 3'b000};
  assign req     = pend & ~clr;
  assign take    = ((state == ST_IDLE) || (state == ST_GAP)) && gnt_vld;
  assign gnt_eff = take ? gnt : 4'b0000;
  assign drop    = cap & pend & ~gnt_eff;

  assign drop_sum   = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
  assign drop_total = {1'b0, drop_q} + 9'(drop_sum);

  led_rr_arbiter u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (take),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  // A capture racing its own grant keeps the new payload pending with ovf clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pend     <= '0;
      ovf      <= '0;
      cfg_prev <= '0;
      drop_q   <= '0;
      for (int i = 0; i < NUM_SRC; i++) payload[i] <= '0;
    end else begin
      cfg_prev <= bus.config_notification;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (clr[i]) begin
          pend[i] <= 1'b0;
          ovf[i]  <= 1'b0;
        end else if (cap[i]) begin
          pend[i]    <= 1'b1;
          ovf[i]     <= drop[i];
          payload[i] <= cap_dat[i];
        end else if (gnt_eff[i]) begin
          pend[i] <= 1'b0;
          ovf[i]  <= 1'b0;
        end
      end
      drop_q <= drop_total[8] ? 8'hFF : drop_total[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      leds_q <= IDLE_PATTERN;
      busy_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_GAP: begin
          if (take) begin
            state  <= ST_SHOW;
            leds_q <= make_pattern(gnt_idx, ovf[gnt_idx], payload[gnt_idx]);
            cnt    <= CNT_LOAD;
            busy_q <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            leds_q <= IDLE_PATTERN;
            busy_q <= 1'b0;
          end
        end
        ST_SHOW: begin
          if (cnt == '0) begin
            state  <= ST_GAP;
            leds_q <= IDLE_PATTERN;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          leds_q <= IDLE_PATTERN;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.leds       = leds_q;
  assign bus.busy       = busy_q;
  assign bus.drop_count = drop_q;

endmodule

// File: tb/tb_led_event_scheduler.sv
// Bench for led_event_scheduler: directed scenarios plus random traffic against an event-level model.
module tb_led_event_scheduler;

  localparam int HOLD = 4;

  logic clk;
  logic rst;
  led_event_scheduler_if ifc ();

  led_event_scheduler #(.HOLD_CYCLES(HOLD), .IDLE_PATTERN(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Event-level model: pending slots as arrays, display as "cycles left to show".
  bit          m_pend [4];
  bit          m_ovf  [4];
  logic [7:0]  m_pay  [4];
  int          m_ptr;
  logic [7:0]  m_cfg_prev;
  logic [15:0] m_leds;
  bit          m_busy;
  int          m_drop;
  int          m_left;
  int          m_phase;   // 0 nothing, 1 showing, 2 blank

  always @(posedge clk) begin
    int          g;
    int          s;
    bit          sw;
    bit          cap [4];
    logic [7:0]  nd  [4];
    logic [15:0] pat;
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[i] = 0;
        m_ovf[i]  = 0;
        m_pay[i]  = 8'h00;
      end
      m_ptr = 0; m_cfg_prev = 8'h00; m_leds = 16'h0000;
      m_busy = 0; m_drop = 0; m_left = 0; m_phase = 0;
    end else begin
      sw  = ifc.UART_data_debug_switch;
      g   = -1;
      pat = 16'h0000;
      if (m_phase != 1) begin
        for (int k = 0; k < 4; k++) begin
          s = (m_ptr + k) % 4;
          if (g < 0 && m_pend[s] && (s != 3 || sw)) g = s;
        end
      end
      if (g >= 0) pat = (16'h8000 >> g) | (m_ovf[g] ? 16'h0800 : 16'h0000) | {8'h00, m_pay[g]};

      cap[0] = ifc.CM_errors_valid;    nd[0] = {4'h0, ifc.CM_errors};
      cap[1] = ifc.UART_errors_valid;  nd[1] = {6'h00, ifc.UART_errors};
      cap[2] = (ifc.config_notification != m_cfg_prev); nd[2] = ifc.config_notification;
      cap[3] = ifc.UART_data_valid && sw; nd[3] = ifc.UART_data;
      m_cfg_prev = ifc.config_notification;

      for (int i = 0; i < 4; i++) begin
        if (i == 3 && !sw) begin
          m_pend[i] = 0; m_ovf[i] = 0;
        end else if (cap[i]) begin
          if (m_pend[i] && i != g) begin
            m_ovf[i] = 1;
            if (m_drop < 255) m_drop++;
          end else begin
            m_ovf[i] = 0;
          end
          m_pend[i] = 1;
          m_pay[i]  = nd[i];
        end else if (i == g) begin
          m_pend[i] = 0; m_ovf[i] = 0;
        end
      end

      if (g >= 0) begin
        m_leds = pat; m_left = HOLD; m_busy = 1; m_phase = 1; m_ptr = (g + 1) % 4;
      end else if (m_phase == 1) begin
        m_left--;
        if (m_left == 0) begin
          m_leds = 16'h0000; m_phase = 2;
        end
      end else if (m_phase == 2) begin
        m_phase = 0; m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("leds", ifc.leds, m_leds);
      chk("busy", 16'(ifc.busy), 16'(m_busy));
      chk("drop_count", 16'(ifc.drop_count), 16'(m_drop));
    end
  end

  task automatic pulse_cm(input logic [3:0] v);
    ifc.CM_errors = v; ifc.CM_errors_valid = 1'b1;
    @(negedge clk);
    ifc.CM_errors_valid = 1'b0;
  endtask

  task automatic pulse_data(input logic [7:0] v);
    ifc.UART_data = v; ifc.UART_data_valid = 1'b1;
    @(negedge clk);
    ifc.UART_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ifc.CM_errors_valid = 1'b0; ifc.UART_errors_valid = 1'b0; ifc.UART_data_valid = 1'b0;
    ifc.config_notification = 8'h00; ifc.UART_data_debug_switch = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic watch_leds(input string tag, input logic [15:0] exp, input int budget);
    int n;
    n = 0;
    while (n < budget && ifc.leds !== exp) begin
      @(negedge clk);
      n++;
    end
    chk(tag, ifc.leds, exp);
  endtask

  initial begin
    rst = 1'b0;
    ifc.UART_data_debug_switch = 1'b1;
    ifc.UART_data = 8'h00;   ifc.UART_data_valid = 1'b0;
    ifc.CM_errors = 4'h0;    ifc.CM_errors_valid = 1'b0;
    ifc.UART_errors = 2'b00; ifc.UART_errors_valid = 1'b0;
    ifc.config_notification = 8'h00;

    // 1: reset and quiet idle
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_leds", ifc.leds, 16'h0000);
    chk("rst_busy", 16'(ifc.busy), 16'h0000);
    chk("rst_drop", 16'(ifc.drop_count), 16'h0000);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", 16'(ifc.busy), 16'h0000);

    // 2: single CM event, exact timing
    pulse_cm(4'hD);
    chk("s2_pending_dark", ifc.leds, 16'h0000);
    @(negedge clk);
    chk("s2_show", ifc.leds, 16'h800D);
    repeat (3) @(negedge clk);
    chk("s2_last_show", ifc.leds, 16'h800D);
    @(negedge clk);
    chk("s2_gap_leds", ifc.leds, 16'h0000);
    chk("s2_gap_busy", 16'(ifc.busy), 16'h0001);
    @(negedge clk);
    chk("s2_idle_busy", 16'(ifc.busy), 16'h0000);

    // 3: three sources in one cycle
    do_reset();
    ifc.CM_errors = 4'hD; ifc.CM_errors_valid = 1'b1;
    ifc.UART_errors = 2'b01; ifc.UART_errors_valid = 1'b1;
    ifc.config_notification = 8'h81;
    @(negedge clk);
    ifc.CM_errors_valid = 1'b0; ifc.UART_errors_valid = 1'b0;
    watch_leds("s3_cm", 16'h800D, 4);
    watch_leds("s3_uerr", 16'h4001, 8);
    watch_leds("s3_cfg", 16'h2081, 8);

    // 4: overwrite while CFG is on display
    do_reset();
    ifc.config_notification = 8'h42;
    @(negedge clk);
    watch_leds("s4_cfg", 16'h2042, 4);
    pulse_cm(4'h1);
    pulse_cm(4'h2);
    watch_leds("s4_cm_ovf", 16'h8802, 12);
    chk("s4_drop", 16'(ifc.drop_count), 16'h0001);

    // 5: debug switch gating
    do_reset();
    ifc.UART_data_debug_switch = 1'b0;
    pulse_data(8'hDD);
    repeat (6) @(negedge clk);
    chk("s5_gated", ifc.leds, 16'h0000);
    ifc.UART_data_debug_switch = 1'b1;
    pulse_data(8'hAA);
    watch_leds("s5_data", 16'h10AA, 4);

    // 6: reset mid-show with DATA pending
    do_reset();
    pulse_data(8'h11);
    watch_leds("s6_show", 16'h1011, 4);
    pulse_data(8'h22);
    rst = 1'b0;
    @(negedge clk);
    chk("s6_rst_leds", ifc.leds, 16'h0000);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("s6_quiet", ifc.leds, 16'h0000);

    // random traffic against the model
    for (int c = 0; c < 2500; c++) begin
      ifc.CM_errors_valid   = ($urandom_range(0, 5) == 0);
      ifc.CM_errors         = 4'($urandom);
      ifc.UART_errors_valid = ($urandom_range(0, 6) == 0);
      ifc.UART_errors       = 2'($urandom);
      ifc.UART_data_valid   = ($urandom_range(0, 4) == 0);
      ifc.UART_data         = 8'($urandom);
      if ($urandom_range(0, 29) == 0) ifc.config_notification = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) ifc.UART_data_debug_switch = ~ifc.UART_data_debug_switch;
      rst = ($urandom_range(0, 899) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    ifc.CM_errors_valid = 1'b0; ifc.UART_errors_valid = 1'b0; ifc.UART_data_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
